// File: rtl/stage2_query_ctrl_if.sv
// Query/result/hash-stage signal bundle for stage2_query_ctrl.
// slave  : the query controller side.
// master : the surrounding logic (upstream queries, hash stage, downstream consumer).
interface stage2_query_ctrl_if #(
    parameter int unsigned DW = 64
);
    // Upstream query channel
    logic          q_valid_i;
    logic [DW-1:0] q_key_i;
    logic          q_ready_o;

    // Hash stage search port
    logic          ins_busy_i;
    logic          search_o;
    logic [DW-1:0] search_data_o;
    logic          search_end_i;
    logic [DW-1:0] search_freq_i;
    logic [DW-1:0] search_latency_i;

    // Downstream result channel
    logic          r_valid_o;
    logic          r_ready_i;
    logic [DW-1:0] r_freq_o;
    logic [DW-1:0] r_latency_o;
    logic [DW-1:0] r_key_o;

    // Status
    logic [1:0]    inflight_o;
    logic          err_o;

    modport slave (
        input  q_valid_i, q_key_i, ins_busy_i,
        input  search_end_i, search_freq_i, search_latency_i,
        input  r_ready_i,
        output q_ready_o, search_o, search_data_o,
        output r_valid_o, r_freq_o, r_latency_o, r_key_o,
        output inflight_o, err_o
    );

    modport master (
        output q_valid_i, q_key_i, ins_busy_i,
        output search_end_i, search_freq_i, search_latency_i,
        output r_ready_i,
        input  q_ready_o, search_o, search_data_o,
        input  r_valid_o, r_freq_o, r_latency_o, r_key_o,
        input  inflight_o, err_o
    );
endinterface

// File: rtl/stage2_query_ctrl.sv
// Query-side controller for the stage-2 sketch hash stage.
// Issues single-cycle search pulses (yielding to inserts), tracks searches in flight,
// captures frequency/latency results on search_end_i and returns them in order through
// a credit-protected show-ahead FIFO.
// Optional feature macro: STAGE2_QUERY_KEY_ECHO_EN -- carries the search key alongside
// each result (2-stage key delay line, FIFO width 3*DW); otherwise r_key_o is tied to 0.
module stage2_query_ctrl #(
    parameter int unsigned DW = 64,
    parameter int unsigned FD = 8,
    parameter int unsigned AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    stage2_query_ctrl_if.slave bus
);

`ifdef STAGE2_QUERY_KEY_ECHO_EN
    localparam int unsigned FW = 3 * DW;
`else
    localparam int unsigned FW = 2 * DW;
`endif

    localparam logic [AW:0]   FD_CNT    = (AW + 1)'(FD);
    localparam logic [AW+1:0] FD_CREDIT = (AW + 2)'(FD);
    localparam logic [1:0]    GUARD_LEN = 2'd2;

    // FIFO storage and bookkeeping
    logic [FW-1:0] mem [FD];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;

    // Search tracking and status
    logic [1:0]    inflight;
    logic [1:0]    guard_cnt;
    logic          err;

    // Decoded per-cycle events
    logic [AW+1:0] credit_used;
    logic          q_ready;
    logic          issue;
    logic          end_seen;
    logic          end_take;
    logic          end_stray;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_ok;
    logic          overflow;
    logic          pop;
    logic [FW-1:0] push_data;
    logic [FW-1:0] head_data;

`ifdef STAGE2_QUERY_KEY_ECHO_EN
    logic [DW-1:0] key_d1;
    logic [DW-1:0] key_d2;

    // Key delay line: key_d2 holds the key issued two cycles ago, aligned to search_end_i
    always_ff @(posedge clk) begin
        if (rst) begin
            key_d1 <= '0;
            key_d2 <= '0;
        end else begin
            key_d1 <= issue ? bus.q_key_i : '0;
            key_d2 <= key_d1;
        end
    end
`endif

    // Credit check, issue decision and result-capture event decode
    always_comb begin
        credit_used = {1'b0, fifo_count} + {{AW{1'b0}}, inflight};
        q_ready     = !rst && !bus.ins_busy_i && (credit_used < FD_CREDIT);
        issue       = bus.q_valid_i && q_ready;

        // Ends inside the post-reset guard window belong to searches issued before reset
        end_seen    = bus.search_end_i && (guard_cnt == '0);
        end_take    = end_seen && (inflight != '0);
        end_stray   = end_seen && (inflight == '0);

        fifo_empty  = (fifo_count == '0);
        fifo_full   = (fifo_count == FD_CNT);
        push_ok     = end_take && !fifo_full;
        overflow    = end_take && fifo_full;
        pop         = !fifo_empty && bus.r_ready_i;

`ifdef STAGE2_QUERY_KEY_ECHO_EN
        push_data   = {key_d2, bus.search_freq_i, bus.search_latency_i};
`else
        push_data   = {bus.search_freq_i, bus.search_latency_i};
`endif
        head_data   = mem[rd_ptr];
    end

    // Result FIFO storage write
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // In-flight search counter: issue increments, captured end decrements
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, end_take})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Post-reset guard window counting down from GUARD_LEN
    always_ff @(posedge clk) begin
        if (rst) begin
            guard_cnt <= GUARD_LEN;
        end else if (guard_cnt != '0) begin
            guard_cnt <= guard_cnt - 1'b1;
        end
    end

    // Sticky protocol error: stray search end or push into a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (end_stray || overflow) begin
            err <= 1'b1;
        end
    end

    // Output drive: search strobe/key and show-ahead head, zeroed when empty
    always_comb begin
        bus.q_ready_o     = q_ready;
        bus.search_o      = issue;
        bus.search_data_o = issue ? bus.q_key_i : '0;
        bus.r_valid_o     = !fifo_empty;
        bus.r_freq_o      = '0;
        bus.r_latency_o   = '0;
        bus.r_key_o       = '0;
        bus.inflight_o    = inflight;
        bus.err_o         = err;
        if (!fifo_empty) begin
            bus.r_freq_o    = head_data[2*DW-1:DW];
            bus.r_latency_o = head_data[DW-1:0];
`ifdef STAGE2_QUERY_KEY_ECHO_EN
            bus.r_key_o     = head_data[3*DW-1:2*DW];
`endif
        end
    end

endmodule

// File: tb/tb_stage2_query_ctrl.sv
// Self-checking bench for stage2_query_ctrl: hash-stage model with fixed 2-cycle latency,
// result scoreboard, combinational vector table and hand-written multi-cycle sequences.
module tb_stage2_query_ctrl;
    localparam int unsigned DW = 64;
    localparam int unsigned FD = 8;
    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage2_query_ctrl_if #(.DW(DW)) bus ();

    stage2_query_ctrl #(.DW(DW), .FD(FD), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] model_freq(input logic [DW-1:0] k);
        return k ^ 64'h6;
    endfunction

    function automatic logic [DW-1:0] model_lat(input logic [DW-1:0] k);
        return k + 64'h3B;
    endfunction

    // Hash stage model: result strobe exactly two cycles after each search pulse
    logic          p1_v = 1'b0;
    logic          p2_v = 1'b0;
    logic [DW-1:0] p1_k = '0;
    logic [DW-1:0] p2_k = '0;
    logic          inj_end = 1'b0;

    always @(posedge clk) begin
        p1_v <= bus.search_o;
        p1_k <= bus.search_data_o;
        p2_v <= p1_v;
        p2_k <= p1_k;
    end

    assign bus.search_end_i     = p2_v | inj_end;
    assign bus.search_freq_i    = p2_v ? model_freq(p2_k) : 64'hDEAD;
    assign bus.search_latency_i = p2_v ? model_lat(p2_k)  : 64'hBEEF;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected results queued on issue, compared on pop
    typedef struct packed {
        logic [DW-1:0] key;
        logic [DW-1:0] freq;
        logic [DW-1:0] lat;
    } res_t;

    res_t sb_q[$];

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.r_valid_o && bus.r_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", bus.r_valid_o, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_freq", bus.r_freq_o, e.freq);
                    check("sb_lat", bus.r_latency_o, e.lat);
`ifdef STAGE2_QUERY_KEY_ECHO_EN
                    check("sb_key", bus.r_key_o, e.key);
`else
                    check("sb_key", bus.r_key_o, '0);
`endif
                end
            end
            if (bus.search_o) begin
                e.key  = bus.search_data_o;
                e.freq = model_freq(bus.search_data_o);
                e.lat  = model_lat(bus.search_data_o);
                sb_q.push_back(e);
            end
        end
    end

    task automatic drive(input logic qv, input logic [DW-1:0] key, input logic busy);
        @(posedge clk);
        #1;
        bus.q_valid_i  = qv;
        bus.q_key_i    = key;
        bus.ins_busy_i = busy;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((sb_q.size() != 0 || bus.inflight_o != 2'd0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.q_valid_i  = 1'b1;
        bus.q_key_i    = 64'h99;
        bus.ins_busy_i = 1'b0;
        bus.r_ready_i  = 1'b0;
        @(negedge clk);
        check("rst_q_ready", bus.q_ready_o, 1'b0);
        check("rst_search", bus.search_o, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_r_valid", bus.r_valid_o, 1'b0);
        check("rst_r_freq", bus.r_freq_o, '0);
        check("rst_inflight", bus.inflight_o, 2'd0);
        check("rst_err", bus.err_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.q_valid_i = 1'b0;
        bus.q_key_i   = '0;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic          qv;
        logic          busy;
        logic [DW-1:0] key;
        logic          exp_rdy;
        logic          exp_srch;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int unsigned idx;
        int unsigned n;

        vecs[0] = '{qv: 1'b0, busy: 1'b0, key: 64'h123, exp_rdy: 1'b1, exp_srch: 1'b0, exp_data: 64'h0};
        vecs[1] = '{qv: 1'b1, busy: 1'b0, key: 64'h123, exp_rdy: 1'b1, exp_srch: 1'b1, exp_data: 64'h123};
        vecs[2] = '{qv: 1'b1, busy: 1'b1, key: 64'h456, exp_rdy: 1'b0, exp_srch: 1'b0, exp_data: 64'h0};
        vecs[3] = '{qv: 1'b0, busy: 1'b1, key: 64'h789, exp_rdy: 1'b0, exp_srch: 1'b0, exp_data: 64'h0};
        vecs[4] = '{qv: 1'b1, busy: 1'b0, key: '1, exp_rdy: 1'b1, exp_srch: 1'b1, exp_data: '1};
        vecs[5] = '{qv: 1'b1, busy: 1'b0, key: 64'h0, exp_rdy: 1'b1, exp_srch: 1'b1, exp_data: 64'h0};
        vecs[6] = '{qv: 1'b1, busy: 1'b0, key: 64'hA5A5_5A5A_0F0F_F0F0, exp_rdy: 1'b1, exp_srch: 1'b1,
                    exp_data: 64'hA5A5_5A5A_0F0F_F0F0};
        vecs[7] = '{qv: 1'b0, busy: 1'b0, key: 64'hFFFF, exp_rdy: 1'b1, exp_srch: 1'b0, exp_data: 64'h0};

        bus.q_valid_i  = 1'b0;
        bus.q_key_i    = '0;
        bus.ins_busy_i = 1'b0;
        bus.r_ready_i  = 1'b0;

        do_reset();

        // Combinational handshake vectors
        bus.r_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].qv, vecs[i].key, vecs[i].busy);
            @(negedge clk);
            check("vec_q_ready", bus.q_ready_o, vecs[i].exp_rdy);
            check("vec_search", bus.search_o, vecs[i].exp_srch);
            check("vec_search_data", bus.search_data_o, vecs[i].exp_data);
        end
        drive(1'b0, '0, 1'b0);
        wait_idle();

        // Single query timing: issue at t, end at t+2, result at t+3
        bus.r_ready_i = 1'b0;
        drive(1'b1, 64'h5, 1'b0);
        @(negedge clk);
        check("t1_search", bus.search_o, 1'b1);
        check("t1_search_data", bus.search_data_o, 64'h5);
        check("t1_inflight_t", bus.inflight_o, 2'd0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("t1_inflight_t1", bus.inflight_o, 2'd1);
        check("t1_r_valid_t1", bus.r_valid_o, 1'b0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("t1_r_valid_t2", bus.r_valid_o, 1'b0);
        check("t1_r_freq_empty", bus.r_freq_o, '0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("t1_r_valid_t3", bus.r_valid_o, 1'b1);
        check("t1_r_freq", bus.r_freq_o, 64'h3);
        check("t1_r_lat", bus.r_latency_o, 64'h40);
        check("t1_inflight_t3", bus.inflight_o, 2'd0);
        drive(1'b0, '0, 1'b0);
        bus.r_ready_i = 1'b1;
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("t1_r_valid_popped", bus.r_valid_o, 1'b0);
        check("t1_inflight_end", bus.inflight_o, 2'd0);

        // Insert priority blocks issue for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h77, 1'b1);
            @(negedge clk);
            check("t2_q_ready_busy", bus.q_ready_o, 1'b0);
            check("t2_search_busy", bus.search_o, 1'b0);
        end
        drive(1'b1, 64'h77, 1'b0);
        @(negedge clk);
        check("t2_search_free", bus.search_o, 1'b1);
        check("t2_search_data", bus.search_data_o, 64'h77);
        drive(1'b0, '0, 1'b0);
        wait_idle();

        // Credit limit: consumer stalled, exactly FD searches issued
        bus.r_ready_i = 1'b0;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            drive(1'b1, 64'h1000 + 64'(idx), 1'b0);
            @(negedge clk);
            if (bus.search_o) idx++;
        end
        check("t3_issued_at_limit", idx, FD);
        check("t3_q_ready_full", bus.q_ready_o, 1'b0);
        n = 0;
        while (idx < 20 && n < 200) begin
            drive(1'b1, 64'h1000 + 64'(idx), 1'b0);
            bus.r_ready_i = 1'b1;
            @(negedge clk);
            if (bus.search_o) idx++;
            n++;
        end
        check("t3_all_issued", idx, 20);
        drive(1'b0, '0, 1'b0);
        wait_idle();
        check("t3_err", bus.err_o, 1'b0);

        // Stray search end with nothing in flight
        drive(1'b0, '0, 1'b0);
        inj_end = 1'b1;
        @(posedge clk);
        #1;
        inj_end = 1'b0;
        @(negedge clk);
        check("t4_r_valid", bus.r_valid_o, 1'b0);
        check("t4_err_set", bus.err_o, 1'b1);
        repeat (5) @(negedge clk);
        check("t4_err_sticky", bus.err_o, 1'b1);
        check("t4_inflight", bus.inflight_o, 2'd0);
        do_reset();

        // Reset with two searches in flight: late ends fall in the guard window
        bus.r_ready_i = 1'b1;
        drive(1'b1, 64'h11, 1'b0);
        drive(1'b1, 64'h12, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.q_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_r_valid", bus.r_valid_o, 1'b0);
            check("t5_err", bus.err_o, 1'b0);
            check("t5_inflight", bus.inflight_o, 2'd0);
            @(posedge clk);
            #1;
        end

        // Back-to-back keys returned in order (key echo checked by the scoreboard)
        drive(1'b1, 64'hA, 1'b0);
        drive(1'b1, 64'hB, 1'b0);
        drive(1'b1, 64'hC, 1'b0);
        drive(1'b0, '0, 1'b0);
        wait_idle();
        check("t6_err", bus.err_o, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
